// File: rtl/silife_grid_pkg.sv
// Shared types and sizes for the SiLife grid control path.
package silife_grid_pkg;

  localparam int unsigned ROW_W     = 5;
  localparam int unsigned CELL_W    = 8;
  localparam int unsigned GRID_ROWS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STEP  = 2'd2
  } grid_state_e;

endpackage

// File: rtl/silife_rr_pick.sv
// Combinational round-robin selector: first asserted request searching upward
// from last_i+1, wrapping modulo N_REQ.
module silife_rr_pick #(
  parameter int unsigned  N_REQ = 2,
  localparam int unsigned OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [OWN_W-1:0] last_i,
  output logic [OWN_W-1:0] owner_o,
  output logic             any_o
);

  always_comb begin
    owner_o = '0;
    any_o   = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned      idx;
      logic [OWN_W-1:0] idx_w;
      idx   = (32'(last_i) + k) % N_REQ;
      idx_w = OWN_W'(idx);
      if (!any_o && req_i[idx_w]) begin
        any_o   = 1'b1;
        owner_o = idx_w;
      end
    end
  end

endmodule

// File: rtl/silife_grid_ctrl.sv
// Row-write arbiter and generation-step scheduler for the SiLife cell grid.
// Optional counters enabled by defining SILIFE_GRID_CTRL_STATS_EN.
module silife_grid_ctrl
  import silife_grid_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned STEP_PERIOD = 4000000,
  parameter int unsigned MAX_BURST   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     run_i,
  input  logic                     single_step_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [ROW_W*N_REQ-1:0]   req_row_i,
  input  logic [CELL_W*N_REQ-1:0]  req_cells_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [ROW_W-1:0]         grid_row_select_o,
  output logic [CELL_W-1:0]        grid_cells_o,
  output logic                     grid_wr_en_o,
  output logic                     grid_step_o,
`ifdef SILIFE_GRID_CTRL_STATS_EN
  output logic [15:0]              gen_count_o,
  output logic [7:0]               step_merged_o,
`endif
  output logic                     busy_o
);

  localparam int unsigned OWN_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W   = $clog2(STEP_PERIOD);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  grid_state_e         state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [OWN_W-1:0]    last_q, last_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CELL_W-1:0]   cells_q, cells_d;
  logic                wr_q, wr_d;
  logic                step_q, step_d;
  logic                busy_q, busy_d;

  logic [ROW_W-1:0]    rows  [N_REQ];
  logic [CELL_W-1:0]   cells [N_REQ];
  logic [OWN_W-1:0]    pick_owner;
  logic                pick_any;
  logic                wrap, step_req, consume, accept;
  logic [BURST_W-1:0]  burst_inc;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign rows[g]  = req_row_i[g*ROW_W +: ROW_W];
    assign cells[g] = req_cells_i[g*CELL_W +: CELL_W];
  end

  silife_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req_i),
    .last_i  (last_q),
    .owner_o (pick_owner),
    .any_o   (pick_any)
  );

  // Period counter and step-pending flag; a request arriving on the consuming edge starts a new step.
  always_comb begin
    wrap     = en_i & run_i & (cnt_q == CNT_W'(STEP_PERIOD - 1));
    cnt_d    = cnt_q;
    if (en_i & run_i) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    step_req = wrap | (single_step_i & en_i);
    consume  = (state_q == IDLE) & en_i & pend_q;
    pend_d   = (pend_q & ~consume) | step_req;
  end

  assign accept    = (state_q == WRITE) & grant_q[owner_q] & req_i[owner_q] & en_i;
  assign burst_inc = burst_q + BURST_W'(1);

  // Next-state and next-output logic for the IDLE/WRITE/STEP sequencer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    row_d   = row_q;
    cells_d = cells_q;
    wr_d    = 1'b0;
    step_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          if (pend_q) begin
            state_d = STEP;
            step_d  = 1'b1;
          end else if (pick_any) begin
            state_d = WRITE;
            owner_d = pick_owner;
            grant_d = N_REQ'(1) << pick_owner;
            burst_d = '0;
          end
        end
      end
      WRITE: begin
        if (accept) begin
          wr_d    = 1'b1;
          row_d   = rows[owner_q];
          cells_d = cells[owner_q];
          burst_d = burst_inc;
        end
        if (!en_i || !req_i[owner_q] ||
            (accept && (burst_inc == BURST_W'(MAX_BURST)))) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
      STEP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) | pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OWN_W'(N_REQ - 1);
      burst_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      row_q   <= '0;
      cells_q <= '0;
      wr_q    <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      row_q   <= row_d;
      cells_q <= cells_d;
      wr_q    <= wr_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o           = grant_q;
  assign grid_row_select_o = row_q;
  assign grid_cells_o      = cells_q;
  assign grid_wr_en_o      = wr_q;
  assign grid_step_o       = step_q;
  assign busy_o            = busy_q;

`ifdef SILIFE_GRID_CTRL_STATS_EN
  logic [15:0] gen_q;
  logic [7:0]  merged_q;
  logic        merged_c;

  assign merged_c = step_req & pend_q & ~consume;

  // Generation counter wraps; merge counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_q    <= '0;
      merged_q <= '0;
    end else begin
      if (step_d) gen_q <= gen_q + 16'd1;
      if (merged_c && (merged_q != 8'hFF)) merged_q <= merged_q + 8'd1;
    end
  end

  assign gen_count_o   = gen_q;
  assign step_merged_o = merged_q;
`endif

endmodule

// File: tb/tb_silife_grid_ctrl.sv
// Directed self-checking bench for silife_grid_ctrl (N_REQ=2, STEP_PERIOD=10, MAX_BURST=32).
module tb_silife_grid_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, run, single_step;
  logic [1:0]  req;
  logic [9:0]  req_row;
  logic [15:0] req_cells;
  logic [1:0]  grant;
  logic [4:0]  grid_row_select;
  logic [7:0]  grid_cells;
  logic        grid_wr_en, grid_step, busy;
`ifdef SILIFE_GRID_CTRL_STATS_EN
  logic [15:0] gen_count;
  logic [7:0]  step_merged;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  silife_grid_ctrl #(.N_REQ(2), .STEP_PERIOD(10), .MAX_BURST(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .en_i              (en),
    .run_i             (run),
    .single_step_i     (single_step),
    .req_i             (req),
    .req_row_i         (req_row),
    .req_cells_i       (req_cells),
    .grant_o           (grant),
    .grid_row_select_o (grid_row_select),
    .grid_cells_o      (grid_cells),
    .grid_wr_en_o      (grid_wr_en),
    .grid_step_o       (grid_step),
`ifdef SILIFE_GRID_CTRL_STATS_EN
    .gen_count_o       (gen_count),
    .step_merged_o     (step_merged),
`endif
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] data0(int i);
    logic [7:0] d;
    d = 8'(i);
    return d ^ 8'hA5;
  endfunction

  task automatic present0(int i);
    req_row[4:0]   = 5'(i);
    req_cells[7:0] = data0(i);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; run = 1'b0; single_step = 1'b0;
    req = 2'b00; req_row = 10'h3E0; req_cells = 16'h5A00;
    #12;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_checks++; if (grid_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", grid_wr_en); end
    n_checks++; if (grid_step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", grid_step); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (grid_row_select !== 5'd0) begin n_fail++; $display("FAIL reset_row: got %0d want 0", grid_row_select); end
    n_checks++; if (grid_cells !== 8'd0) begin n_fail++; $display("FAIL reset_cells: got %h want 00", grid_cells); end
`ifdef SILIFE_GRID_CTRL_STATS_EN
    n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL reset_gen_count: got %0d want 0", gen_count); end
`endif
    tick();
    rst = 1'b0; en = 1'b1;
    tick(); tick();
  endtask

  task automatic test_single_burst();
    req = 2'b01; present0(0);
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL burst_grant_rise: got %b want 01", grant); end
    n_checks++; if (grid_wr_en !== 1'b0) begin n_fail++; $display("FAIL burst_first_wr: got %b want 0", grid_wr_en); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_busy: got %b want 1", busy); end
    for (int i = 0; i < 32; i++) begin
      present0(i);
      tick();
      n_checks++; if (grid_wr_en !== 1'b1) begin n_fail++; $display("FAIL burst_wr[%0d]: got %b want 1", i, grid_wr_en); end
      n_checks++; if (grid_row_select !== 5'(i)) begin n_fail++; $display("FAIL burst_row[%0d]: got %0d want %0d", i, grid_row_select, i); end
      n_checks++; if (grid_cells !== data0(i)) begin n_fail++; $display("FAIL burst_cells[%0d]: got %h want %h", i, grid_cells, data0(i)); end
      n_checks++;
      if (grant !== ((i < 31) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL burst_grant[%0d]: got %b want %b", i, grant, (i < 31) ? 2'b01 : 2'b00);
      end
    end
    req = 2'b00;
    tick();
    n_checks++; if (grid_wr_en !== 1'b0) begin n_fail++; $display("FAIL burst_end_wr: got %b want 0", grid_wr_en); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL burst_end_grant: got %b want 00", grant); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    req = 2'b11; present0(3); req_row[9:5] = 5'd17; req_cells[15:8] = 8'h3C;
    for (int b = 0; b < 3; b++) begin
      exp = (b % 2 == 0) ? 2'b10 : 2'b01;
      for (int c = 0; c < 32; c++) begin
        tick();
        n_checks++; if (grant !== exp) begin n_fail++; $display("FAIL alt_grant b%0d c%0d: got %b want %b", b, c, grant, exp); end
      end
      tick();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL alt_idle b%0d: got %b want 00", b, grant); end
      if (b == 0) begin
        n_checks++; if (grid_row_select !== 5'd17) begin n_fail++; $display("FAIL alt_row1: got %0d want 17", grid_row_select); end
      end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_period_step();
    logic exp_step, exp_busy;
    run = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      exp_step = (k >= 11) && ((k - 11) % 10 == 0);
      exp_busy = (k >= 10) && ((k - 10) % 10 < 2);
      n_checks++; if (grid_step !== exp_step) begin n_fail++; $display("FAIL period_step k%0d: got %b want %b", k, grid_step, exp_step); end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL period_busy k%0d: got %b want %b", k, busy, exp_busy); end
      n_checks++; if (grid_wr_en !== 1'b0) begin n_fail++; $display("FAIL period_wr k%0d: got %b want 0", k, grid_wr_en); end
    end
    run = 1'b0;
  endtask

  task automatic test_en_hold();
    en = 1'b0; run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      single_step = (k == 4);
      tick();
      n_checks++; if (grid_step !== 1'b0) begin n_fail++; $display("FAIL hold_step k%0d: got %b want 0", k, grid_step); end
    end
    single_step = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++; if (grid_step !== (k == 6)) begin n_fail++; $display("FAIL hold_resume k%0d: got %b want %b", k, grid_step, (k == 6)); end
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_step_in_burst();
    req = 2'b01; present0(0);
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL sib_grant: got %b want 01", grant); end
    for (int i = 0; i < 32; i++) begin
      present0(i);
      single_step = (i == 3) || (i == 7);
      tick();
      single_step = 1'b0;
      n_checks++; if (grid_step !== 1'b0) begin n_fail++; $display("FAIL sib_early_step[%0d]: got %b want 0", i, grid_step); end
      n_checks++; if (grid_wr_en !== 1'b1) begin n_fail++; $display("FAIL sib_wr[%0d]: got %b want 1", i, grid_wr_en); end
    end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL sib_release: got %b want 00", grant); end
    tick();
    n_checks++; if (grid_step !== 1'b1) begin n_fail++; $display("FAIL sib_step: got %b want 1", grid_step); end
    n_checks++; if (grid_wr_en !== 1'b0) begin n_fail++; $display("FAIL sib_step_wr: got %b want 0", grid_wr_en); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL sib_step_grant: got %b want 00", grant); end
    req = 2'b00;
    tick();
    n_checks++; if (grid_step !== 1'b0) begin n_fail++; $display("FAIL sib_once: got %b want 0", grid_step); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sib_busy: got %b want 0", busy); end
`ifdef SILIFE_GRID_CTRL_STATS_EN
    n_checks++; if (gen_count !== 16'd6) begin n_fail++; $display("FAIL stats_gen: got %0d want 6", gen_count); end
    n_checks++; if (step_merged !== 8'd1) begin n_fail++; $display("FAIL stats_merged: got %0d want 1", step_merged); end
`endif
  endtask

  task automatic test_en_drop();
    req = 2'b01; present0(0);
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL endrop_grant: got %b want 01", grant); end
    for (int i = 0; i < 5; i++) begin
      present0(i);
      tick();
      n_checks++; if (grid_row_select !== 5'(i)) begin n_fail++; $display("FAIL endrop_row[%0d]: got %0d want %0d", i, grid_row_select, i); end
    end
    present0(5); en = 1'b0;
    tick();
    n_checks++; if (grid_wr_en !== 1'b0) begin n_fail++; $display("FAIL endrop_wr: got %b want 0", grid_wr_en); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL endrop_grant0: got %b want 00", grant); end
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL endrop_hold: got %b want 00", grant); end
    en = 1'b1;
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL endrop_regrant: got %b want 01", grant); end
    n_checks++; if (grid_wr_en !== 1'b0) begin n_fail++; $display("FAIL endrop_regrant_wr: got %b want 0", grid_wr_en); end
    tick();
    n_checks++; if (grid_wr_en !== 1'b1) begin n_fail++; $display("FAIL endrop_resume_wr: got %b want 1", grid_wr_en); end
    n_checks++; if (grid_row_select !== 5'd5) begin n_fail++; $display("FAIL endrop_resume_row: got %0d want 5", grid_row_select); end
    n_checks++; if (grid_cells !== data0(5)) begin n_fail++; $display("FAIL endrop_resume_cells: got %h want %h", grid_cells, data0(5)); end
    req = 2'b00;
    tick();
    n_checks++; if (grid_wr_en !== 1'b0) begin n_fail++; $display("FAIL endrop_done_wr: got %b want 0", grid_wr_en); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL endrop_done_grant: got %b want 00", grant); end
  endtask

  task automatic test_reset_mid();
    req = 2'b01; present0(9);
    tick();
    for (int i = 0; i < 3; i++) begin
      single_step = (i == 1);
      tick();
      single_step = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rstmid_grant: got %b want 00", grant); end
    n_checks++; if (grid_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr: got %b want 0", grid_wr_en); end
    n_checks++; if (grid_row_select !== 5'd0) begin n_fail++; $display("FAIL rstmid_row: got %0d want 0", grid_row_select); end
    n_checks++; if (grid_cells !== 8'd0) begin n_fail++; $display("FAIL rstmid_cells: got %h want 00", grid_cells); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
`ifdef SILIFE_GRID_CTRL_STATS_EN
    n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_gen: got %0d want 0", gen_count); end
    n_checks++; if (step_merged !== 8'd0) begin n_fail++; $display("FAIL rstmid_merged: got %0d want 0", step_merged); end
`endif
    req = 2'b00;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (grid_step !== 1'b0) begin n_fail++; $display("FAIL rstmid_lost_step k%0d: got %b want 0", k, grid_step); end
    end
    req = 2'b11;
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rstmid_first_owner: got %b want 01", grant); end
    req = 2'b00;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_period_step();
    test_en_hold();
    test_step_in_burst();
    test_en_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
